core_lsu: RTL and testbench



---
 rtl/core_lsu.sv | 231 +++++++++++++++++++++++
 tb/tb_core_lsu.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_lsu.sv
`default_nettype none
// ============================================================================
// Module   : core_lsu
// Purpose  : Load/store unit with valid/ready handshakes toward the core and
//            the memory bus. Handles byte/half/word sizes with sign or zero
//            extension and aborts a beat that stalls for TIMEOUT cycles.
//            Define CORE_LSU_MISALIGNED_EN to split word-crossing half/word
//            accesses into two bus beats. Without it they end with rsp_err.
// Revision : 1.0 - initial release
// ============================================================================
module core_lsu #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  // core side
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  // bus side
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       data_out,
  input  logic [31:0]       data_in,
  output logic              we,
  output logic [3:0]        byte_en,
  output logic              bus_valid,
  input  logic              bus_ready
);

  localparam int              c_cnt_w    = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Active byte lanes for an access starting at lane 0.
  function automatic logic [3:0] lane_mask(input logic [1:0] size);
    case (size)
      2'd0:    lane_mask = 4'b0001;
      2'd1:    lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Captured request and beat bookkeeping
  logic [1:0]         r_off;
  logic [1:0]         r_size;
  logic               r_unsigned;
  logic               r_store;
  logic               r_err;
  logic [c_cnt_w-1:0] r_cnt;
  logic [31:0]        r_d0;

  logic [1:0]  w_req_off;
  logic        w_cross;
  logic        w_err_req;
  logic        w_stall;
  logic        w_timeout;
  logic        w_beat_done;
  logic [3:0]  w_mask0;
  logic [31:0] w_wdata0;
  logic [31:0] w_raw;
  logic [31:0] w_load;

  assign w_req_off = req_addr[1:0];
  // A half at lane 3 or a word off lane 0 spills into the next word.
  assign w_cross   = (req_size == 2'd1 && w_req_off == 2'd3) ||
                     (req_size == 2'd2 && w_req_off != 2'd0);
  assign w_mask0   = lane_mask(req_size) << w_req_off;
  assign w_wdata0  = req_wdata << {w_req_off, 3'b000};

  assign w_stall     = bus_valid & ~bus_ready;
  assign w_beat_done = bus_valid & bus_ready;
  assign w_timeout   = w_stall && (r_cnt == c_cnt_last);

`ifdef CORE_LSU_MISALIGNED_EN
  logic        r_cross;
  logic [31:0] r_wdata;
  logic [31:0] r_d1;
  logic [3:0]  w_mask1;
  logic [31:0] w_wdata1;

  assign w_err_req = (req_size == 2'd3);
  // Second beat takes the lanes and data bytes that overflowed beat 0.
  assign w_mask1   = 4'(({4'b0000, lane_mask(r_size)} << r_off) >> 4);
  assign w_wdata1  = r_wdata >> (6'd32 - {1'b0, r_off, 3'b000});
  assign w_raw     = 32'({r_d1, r_d0} >> {r_off, 3'b000});
`else
  assign w_err_req = (req_size == 2'd3) || w_cross;
  assign w_raw     = r_d0 >> {r_off, 3'b000};
`endif

  // Truncate the aligned load value to its size and extend it to 32 bits.
  always_comb begin
    w_load = w_raw;
    case (r_size)
      2'd0:    w_load = {{24{~r_unsigned & w_raw[7]}},  w_raw[7:0]};
      2'd1:    w_load = {{16{~r_unsigned & w_raw[15]}}, w_raw[15:0]};
      default: w_load = w_raw;
    endcase
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == DONE);
  assign rsp_err   = rsp_valid & r_err;
  assign rsp_rdata = (rsp_valid && !r_err && !r_store) ? w_load : 32'h0;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state selection.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) w_state_next = w_err_req ? DONE : BEAT0;
      end
      BEAT0: begin
        if (w_timeout) begin
          w_state_next = DONE;
        end else if (w_beat_done) begin
`ifdef CORE_LSU_MISALIGNED_EN
          w_state_next = r_cross ? BEAT1 : DONE;
`else
          w_state_next = DONE;
`endif
        end
      end
`ifdef CORE_LSU_MISALIGNED_EN
      BEAT1: begin
        if (w_timeout || w_beat_done) w_state_next = DONE;
      end
`endif
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Request capture, bus beat registers, read data and stall counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_off      <= 2'd0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_store    <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
      r_d0       <= 32'h0;
      address    <= '0;
      data_out   <= 32'h0;
      we         <= 1'b0;
      byte_en    <= 4'h0;
      bus_valid  <= 1'b0;
`ifdef CORE_LSU_MISALIGNED_EN
      r_cross    <= 1'b0;
      r_wdata    <= 32'h0;
      r_d1       <= 32'h0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_off      <= w_req_off;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_store    <= req_we;
            r_err      <= w_err_req;
            r_cnt      <= '0;
`ifdef CORE_LSU_MISALIGNED_EN
            r_cross    <= w_cross;
            r_wdata    <= req_wdata;
`endif
            if (!w_err_req) begin
              bus_valid <= 1'b1;
              address   <= {req_addr[ADDR_W-1:2], 2'b00};
              byte_en   <= w_mask0;
              data_out  <= w_wdata0;
              we        <= req_we;
            end
          end
        end
        BEAT0, BEAT1: begin
          if (w_beat_done) begin
            r_cnt <= '0;
`ifdef CORE_LSU_MISALIGNED_EN
            if (r_state == BEAT0) r_d0 <= data_in;
            else                  r_d1 <= data_in;
            if (r_state == BEAT0 && r_cross) begin
              address  <= address + ADDR_W'(4);
              byte_en  <= w_mask1;
              data_out <= w_wdata1;
            end else begin
              bus_valid <= 1'b0;
            end
`else
            r_d0      <= data_in;
            bus_valid <= 1'b0;
`endif
          end else if (w_timeout) begin
            bus_valid <= 1'b0;
            r_err     <= 1'b1;
          end else if (w_stall) begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_lsu
// Purpose  : Directed self-checking bench for core_lsu (TIMEOUT = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_lsu;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] address;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic        we;
  logic [3:0]  byte_en;
  logic        bus_valid;
  logic        bus_ready;

  int n_cmp;
  int n_mis;

  core_lsu #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .address      (address),
    .data_out     (data_out),
    .data_in      (data_in),
    .we           (we),
    .byte_en      (byte_en),
    .bus_valid    (bus_valid),
    .bus_ready    (bus_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] s,
                       input logic u, input logic [31:0] d);
    chk("req_ready_idle", 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_we = w; req_addr = a; req_size = s;
    req_unsigned = u; req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Complete one bus beat with the given read data.
  task automatic beat(input logic [31:0] d);
    bus_ready = 1'b1; data_in = d;
    @(negedge clk);
    bus_ready = 1'b0; data_in = 32'h0;
  endtask

  // Check the response pulse and the return to IDLE.
  task automatic finish_rsp(input string tag, input logic err, input logic [31:0] rd);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h1);
    chk({tag, "_rsp_err"},   32'(rsp_err),   32'(err));
    chk({tag, "_rsp_rdata"}, rsp_rdata,      rd);
    chk({tag, "_bus_idle"},  32'(bus_valid), 32'h0);
    @(negedge clk);
    chk({tag, "_rsp_drop"},  32'(rsp_valid), 32'h0);
    chk({tag, "_ready_back"}, 32'(req_ready), 32'h1);
  endtask

  initial begin
    n_cmp = 0; n_mis = 0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'h0;
    data_in = 32'h0; bus_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_err",   32'(rsp_err),   32'h0);
    chk("rst_rsp_rdata", rsp_rdata,      32'h0);
    chk("rst_bus_valid", 32'(bus_valid), 32'h0);
    chk("rst_address",   address,        32'h0);
    chk("rst_data_out",  data_out,       32'h0);
    chk("rst_we",        32'(we),        32'h0);
    chk("rst_byte_en",   32'(byte_en),   32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Aligned word load, zero-wait
    issue(1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
    chk("lw_bus_valid", 32'(bus_valid), 32'h1);
    chk("lw_address",   address,        32'h100);
    chk("lw_byte_en",   32'(byte_en),   32'hF);
    chk("lw_we",        32'(we),        32'h0);
    chk("lw_no_rsp_yet", 32'(rsp_valid), 32'h0);
    beat(32'hDEADBEEF);
    finish_rsp("lw", 1'b0, 32'hDEADBEEF);

    // Signed byte load at lane 3
    issue(1'b0, 32'h103, 2'd0, 1'b0, 32'h0);
    chk("lb_address", address,      32'h100);
    chk("lb_byte_en", 32'(byte_en), 32'h8);
    beat(32'h80000000);
    finish_rsp("lb", 1'b0, 32'hFFFFFF80);

    // Unsigned byte load at lane 3
    issue(1'b0, 32'h103, 2'd0, 1'b1, 32'h0);
    chk("lbu_byte_en", 32'(byte_en), 32'h8);
    beat(32'h80000000);
    finish_rsp("lbu", 1'b0, 32'h00000080);

    // Half store at lane 2
    issue(1'b1, 32'h102, 2'd1, 1'b0, 32'h00001234);
    chk("sh_address",  address,        32'h100);
    chk("sh_byte_en",  32'(byte_en),   32'hC);
    chk("sh_data_out", data_out,       32'h12340000);
    chk("sh_we",       32'(we),        32'h1);
    beat(32'h0);
    finish_rsp("sh", 1'b0, 32'h0);

    // Unsigned half load at lane 1 (inside one word, not misaligned)
    issue(1'b0, 32'h101, 2'd1, 1'b1, 32'h0);
    chk("lhu1_bus_valid", 32'(bus_valid), 32'h1);
    chk("lhu1_byte_en",   32'(byte_en),   32'h6);
    beat(32'h00ABCD00);
    finish_rsp("lhu1", 1'b0, 32'h0000ABCD);

    // Signed half load with two wait states
    issue(1'b0, 32'h102, 2'd1, 1'b0, 32'h0);
    chk("lhw_byte_en", 32'(byte_en), 32'hC);
    @(negedge clk);
    @(negedge clk);
    chk("lhw_still_valid", 32'(bus_valid), 32'h1);
    chk("lhw_addr_held",   address,        32'h100);
    chk("lhw_no_rsp",      32'(rsp_valid), 32'h0);
    beat(32'hBEEF0000);
    finish_rsp("lhw", 1'b0, 32'hFFFFBEEF);

`ifdef CORE_LSU_MISALIGNED_EN
    // Misaligned word load split across two beats
    issue(1'b0, 32'h101, 2'd2, 1'b0, 32'h0);
    chk("mlw_b0_address", address,      32'h100);
    chk("mlw_b0_byte_en", 32'(byte_en), 32'hE);
    beat(32'h44332211);
    chk("mlw_b1_valid",   32'(bus_valid), 32'h1);
    chk("mlw_b1_address", address,        32'h104);
    chk("mlw_b1_byte_en", 32'(byte_en),   32'h1);
    beat(32'h88776655);
    finish_rsp("mlw", 1'b0, 32'h55443322);

    // Misaligned half store at lane 3
    issue(1'b1, 32'h103, 2'd1, 1'b0, 32'h0000ABCD);
    chk("msh_b0_byte_en", 32'(byte_en), 32'h8);
    chk("msh_b0_data",    data_out,     32'hCD000000);
    beat(32'h0);
    chk("msh_b1_address", address,      32'h104);
    chk("msh_b1_byte_en", 32'(byte_en), 32'h1);
    chk("msh_b1_data",    data_out,     32'h000000AB);
    beat(32'h0);
    finish_rsp("msh", 1'b0, 32'h0);
`else
    // Misaligned word load rejected without bus traffic
    issue(1'b0, 32'h101, 2'd2, 1'b0, 32'h0);
    chk("mlw_no_bus", 32'(bus_valid), 32'h0);
    finish_rsp("mlw", 1'b1, 32'h0);

    // Misaligned half store rejected without bus traffic
    issue(1'b1, 32'h103, 2'd1, 1'b0, 32'h0000ABCD);
    chk("msh_no_bus", 32'(bus_valid), 32'h0);
    finish_rsp("msh", 1'b1, 32'h0);
`endif

    // Timeout: bus never ready, bus_valid high exactly 4 cycles
    issue(1'b0, 32'h200, 2'd2, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("to_valid_high", 32'(bus_valid), 32'h1);
      chk("to_addr_held",  address,        32'h200);
      chk("to_no_rsp",     32'(rsp_valid), 32'h0);
      @(negedge clk);
    end
    finish_rsp("to", 1'b1, 32'h0);

    // Reset in the middle of a stalled store beat
    issue(1'b1, 32'h300, 2'd2, 1'b0, 32'hCAFEF00D);
    chk("rmb_we",       32'(we),        32'h1);
    chk("rmb_data_out", data_out,       32'hCAFEF00D);
    #2 reset = 1'b1;
    #1;
    chk("rmb_valid_drop", 32'(bus_valid), 32'h0);
    chk("rmb_we_drop",    32'(we),        32'h0);
    chk("rmb_no_rsp",     32'(rsp_valid), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    chk("rmb_ready_after", 32'(req_ready), 32'h1);
    @(negedge clk);
    chk("rmb_no_rsp_after", 32'(rsp_valid), 32'h0);
    chk("rmb_bus_idle",     32'(bus_valid), 32'h0);

    // Illegal size: error response one cycle after accept
    issue(1'b0, 32'h400, 2'd3, 1'b0, 32'h0);
    chk("ill_no_bus", 32'(bus_valid), 32'h0);
    finish_rsp("ill", 1'b1, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
